// File: rtl/tdm_demux14_if.sv
// TDM sample stream: one sample per din_valid beat, frame_sync marks slot 0.
interface tdm_demux14_if #(
  parameter int W = 8
);
  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_sync;

  modport master (output din, din_valid, frame_sync);
  modport slave  (input  din, din_valid, frame_sync);
endinterface

// File: rtl/tdm_demux14.sv
// 1:4 TDM demux with frame-alignment FSM (HUNT/LOCKED); din -> yk latency 1 clk.
// No backpressure: every valid beat is consumed or dropped in the cycle it arrives.
module tdm_demux14 #(
  parameter int W      = 8,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  tdm_demux14_if.slave      s,
  output logic [W-1:0]      y0,
  output logic [W-1:0]      y1,
  output logic [W-1:0]      y2,
  output logic [W-1:0]      y3,
  output logic [3:0]        y_valid,
  output logic              frame_done,
  output logic              sync_err,
  output logic              locked,
  output logic [FCNT_W-1:0] frame_cnt
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t     state;
  logic [1:0] slot;

  assign locked = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      slot       <= 2'd0;
      y0         <= '0;
      y1         <= '0;
      y2         <= '0;
      y3         <= '0;
      y_valid    <= 4'b0000;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      y_valid    <= 4'b0000;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (s.din_valid) begin
        case (state)
          HUNT: begin
            if (s.frame_sync) begin
              y0      <= s.din;
              y_valid <= 4'b0001;
              slot    <= 2'd1;
              state   <= LOCKED;
            end
          end
          LOCKED: begin
            if (s.frame_sync) begin
              // Sync anywhere but slot 0 abandons the partial frame and restarts it.
              sync_err <= (slot != 2'd0);
              y0       <= s.din;
              y_valid  <= 4'b0001;
              slot     <= 2'd1;
            end else if (slot == 2'd0) begin
              sync_err <= 1'b1;
              state    <= HUNT;
            end else begin
              case (slot)
                2'd1:    y1 <= s.din;
                2'd2:    y2 <= s.din;
                default: y3 <= s.din;
              endcase
              y_valid <= 4'b0001 << slot;
              slot    <= slot + 2'd1;
              if (slot == 2'd3) begin
                frame_done <= 1'b1;
                frame_cnt  <= frame_cnt + FCNT_W'(1);
              end
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
